multicycle_controller: RTL

//  Moore FSM sequencing the multicycle MIPS datapath: one shared memory, one ALU, IR/MDR/A/B/ALUOut regs.

---
 rtl/multicycle_controller_pkg.sv | 61 ++++++
 rtl/mc_opcode_decode.sv | 27 ++
 rtl/multicycle_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// ==== multicycle_controller_pkg: opcodes, FSM states, instruction classes, datapath mux codes ====
// Rev 1.0
`default_nettype none

package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FETCH is encoded as zero so the debug port reads FETCH while reset forces it low.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_IMM     = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_e;

endpackage

`default_nettype wire

// File: rtl/mc_opcode_decode.sv
// ==== mc_opcode_decode: combinational opcode to instruction-class decode ====
// Rev 1.0
`default_nettype none

module mc_opcode_decode
  import multicycle_controller_pkg::*;
(
  input  logic [5:0]   opcode,
  output instr_class_e cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE:                                  cls = CLS_RTYPE;
      OP_LW:                                     cls = CLS_LOAD;
      OP_SW:                                     cls = CLS_STORE;
      OP_BEQ:                                    cls = CLS_BEQ;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: cls = CLS_IMM;
      OP_J:                                      cls = CLS_JUMP;
      default:                                   cls = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ==== multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath ====
// Rev 1.0
`default_nettype none

module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int MEM_HS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               halt_req,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               pc_en,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  state_e       r_state;
  state_e       w_next;
  state_e       w_boundary;
  instr_class_e w_class;
  logic         w_ready;

  mc_opcode_decode u_decode (
    .opcode (opcode),
    .cls    (w_class)
  );

  assign w_ready    = (MEM_HS != 0) ? mem_ready : 1'b1;
  // Every instruction-ending transition funnels through here so halt is only taken at a boundary.
  assign w_boundary = halt_req ? S_HALT : S_FETCH;
  assign state      = rst ? '0 : STATE_W'(r_state);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (w_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            w_next  = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM_SH2;
          case (w_class)
            CLS_RTYPE:           w_next = S_EXEC;
            CLS_LOAD, CLS_STORE: w_next = S_MEMADR;
            CLS_BEQ:             w_next = S_BRANCH;
            CLS_IMM:             w_next = S_IEXEC;
            CLS_JUMP:            w_next = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              w_next     = w_boundary;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          w_next  = (w_class == CLS_LOAD) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          if (w_ready) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          MemToReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          w_next     = w_boundary;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (w_ready) begin
            instr_done = 1'b1;
            w_next     = w_boundary;
          end
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
          w_next  = S_RWB;
        end
        S_RWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          w_next     = w_boundary;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_IMM;
          w_next  = S_IWB;
        end
        S_IWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          w_next     = w_boundary;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
          w_next      = w_boundary;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
          w_next     = w_boundary;
        end
        S_HALT: begin
          halted = 1'b1;
          if (!halt_req) w_next = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
    pc_en = PCWrite | (PCWriteCond & zero);
  end

endmodule

`default_nettype wire
